// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the LEGv8 data-memory responder.
package dmem_pkg;

  typedef enum logic {CLEAR, READY} dmemState_e;

  localparam int CNT_W = 32;

  // Width of the word index (and the clear counter) for a given array depth.
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_clear_fsm.sv
// Post-reset zero-fill sequencer: walks every word index once, then hands the
// array over to the pipeline.
module dmem_clear_fsm
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int IW   = idxWidth(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          clear_we,
  output logic [IW-1:0] clear_idx
);

  dmemState_e    state, stateNxt;
  logic [IW-1:0] clrIdx, clrIdxNxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= CLEAR;
      clrIdx <= '0;
    end else begin
      state  <= stateNxt;
      clrIdx <= clrIdxNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    clrIdxNxt = clrIdx;
    busy      = 1'b0;
    clear_we  = 1'b0;
    clear_idx = clrIdx;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        clear_we = 1'b1;
        // Leave on the last index so the counter never wraps.
        if (clrIdx == IW'(DEPTH - 1)) stateNxt  = READY;
        else                          clrIdxNxt = clrIdx + 1'b1;
      end
      READY:   ;
      default: stateNxt = CLEAR;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the LEGv8 MEM stage: word-addressed N-bit array,
// zero-latency loads, one-edge stores, sticky illegal-access flag.
// Optional DMEM_PERF_CNT_EN adds saturating rd_count / wr_count outputs.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     DM_addr,
  input  logic [N-1:0]     DM_writeData,
  input  logic             DM_writeEnable,
  input  logic             DM_readEnable,
  output logic [N-1:0]     DM_readData,
  output logic             busy,
  output logic             err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
`endif
);

  localparam int           IW         = idxWidth(DEPTH);
  localparam logic [N-1:0] ADDR_LIMIT = N'(DEPTH) << 3;

  logic [N-1:0]  mem [DEPTH];
  logic          clearWe;
  logic [IW-1:0] clearIdx;
  logic [IW-1:0] wordIdx;
  logic          illegal, loadOk, storeOk, badAccess;

  dmem_clear_fsm #(.DEPTH(DEPTH)) uClear (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .clear_we  (clearWe),
    .clear_idx (clearIdx)
  );

  assign wordIdx   = DM_addr[IW+2:3];
  assign illegal   = (DM_addr[2:0] != 3'b000) || (DM_addr >= ADDR_LIMIT);
  assign loadOk    = !busy && DM_readEnable  && !illegal;
  assign storeOk   = !busy && DM_writeEnable && !illegal;
  assign badAccess = !busy && (DM_readEnable || DM_writeEnable) && illegal;

  // Read is combinational so the old word is seen on a same-cycle load+store.
  assign DM_readData = loadOk ? mem[wordIdx] : '0;

  // No async reset on the array; a store coinciding with reset is gated off.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (clearWe)      mem[clearIdx] <= '0;
      else if (storeOk) mem[wordIdx]  <= DM_writeData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         err <= 1'b0;
    else if (badAccess) err <= 1'b1;
  end

`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (loadOk  && rd_count != '1) rd_count <= rd_count + 1'b1;
      if (storeOk && wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a flat array model.
module tb_dmem_responder;

  localparam int N     = 64;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  DM_addr = '0;
  logic [N-1:0]  DM_writeData = '0;
  logic          DM_writeEnable = 1'b0;
  logic          DM_readEnable = 1'b0;
  logic [N-1:0]  DM_readData;
  logic          busy;
  logic          err;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0]   rd_count, wr_count;
`endif

  dmem_responder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .DM_readEnable  (DM_readEnable),
    .DM_readData    (DM_readData),
    .busy           (busy),
    .err            (err)
`ifdef DMEM_PERF_CNT_EN
    ,
    .rd_count       (rd_count),
    .wr_count       (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [N-1:0] mdl [DEPTH];
  logic         mErr;
  int           mRd, mWr;

  function automatic bit isLegal(input logic [N-1:0] a);
    return (a % 8 == 0) && (a < DEPTH * 8);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mErr = 1'b0;
    mRd  = 0;
    mWr  = 0;
  endtask

  task automatic idle();
    DM_writeEnable = 1'b0;
    DM_readEnable  = 1'b0;
    DM_addr        = '0;
    DM_writeData   = '0;
  endtask

  // One READY-phase access: check the load data before the edge, err after it.
  task automatic access(input logic we, input logic re, input logic [N-1:0] a,
                        input logic [N-1:0] wd, input string nm);
    logic [N-1:0] exp;
    bit ok;
    @(negedge clk);
    DM_writeEnable = we;
    DM_readEnable  = re;
    DM_addr        = a;
    DM_writeData   = wd;
    #1;
    ok  = isLegal(a);
    exp = (re && ok) ? mdl[a / 8] : '0;
    total++;
    if (DM_readData !== exp) begin
      bad++;
      $display("FAIL %s rdata addr=%h got=%h exp=%h", nm, a, DM_readData, exp);
    end
    @(posedge clk);
    if (we && ok) mdl[a / 8] = wd;
    if ((we || re) && !ok) mErr = 1'b1;
    if (re && ok) mRd++;
    if (we && ok) mWr++;
    #1;
    total++;
    if (err !== mErr) begin
      bad++;
      $display("FAIL %s err got=%b exp=%b", nm, err, mErr);
    end
  endtask

  // Bounded wait for the clear sequence; returns edges seen while busy.
  task automatic waitReady(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc;
    idle();
    DM_readEnable = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || err !== 1'b0 || DM_readData !== '0) begin
      bad++;
      $display("FAIL reset_vals busy=%b err=%b rdata=%h exp busy=1 err=0 rdata=0",
               busy, err, DM_readData);
    end
    idle();
    @(negedge clk);
    reset = 1'b1;
    waitReady(cyc);
    total++;
    if (cyc != DEPTH || busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_len got=%0d busy=%b exp=%0d busy=0", cyc, busy, DEPTH);
    end
    modelReset();
    access(1'b0, 1'b1, 64'h0,   '0, "read_0");
    access(1'b0, 1'b1, 64'h1F8, '0, "read_1f8");
  endtask

  task automatic test_store_load();
    access(1'b1, 1'b0, 64'h10, 64'hDEAD_BEEF_0000_0001, "st_10");
    access(1'b0, 1'b1, 64'h10, '0, "ld_10");
    access(1'b1, 1'b1, 64'h10, 64'h5, "rw_same");
    access(1'b0, 1'b1, 64'h10, '0, "ld_after_rw");
  endtask

  task automatic test_illegal();
    access(1'b1, 1'b0, 64'h0C,  64'h1234, "st_misalign");
    access(1'b0, 1'b1, 64'h08,  '0, "ld_08_unchanged");
    access(1'b0, 1'b1, 64'h200, '0, "ld_oor");
    access(1'b1, 1'b1, 64'h1F8, 64'hA5A5, "rw_top");
    access(1'b0, 1'b1, 64'h1F8, '0, "ld_top");
  endtask

  task automatic test_clear_ignore();
    int cyc;
    idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    DM_writeEnable = 1'b1;
    DM_readEnable  = 1'b1;
    DM_addr        = 64'h08;
    DM_writeData   = 64'h7;
    #1;
    total++;
    if (DM_readData !== '0) begin
      bad++;
      $display("FAIL clear_rdata got=%h exp=0", DM_readData);
    end
    @(negedge clk);
    DM_addr = 64'h0C;
    @(negedge clk);
    idle();
    waitReady(cyc);
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL clear_ignore busy=%b err=%b exp busy=0 err=0", busy, err);
    end
    modelReset();
    access(1'b0, 1'b1, 64'h08, '0, "ld_08_after_clear");
  endtask

  task automatic test_reset_midstream();
    int cyc;
    access(1'b1, 1'b0, 64'h08, 64'hFF, "st_08_ff");
    access(1'b1, 1'b0, 64'h0C, 64'h1,  "st_misalign2");
    @(negedge clk);
    DM_writeEnable = 1'b1;
    DM_addr        = 64'h10;
    DM_writeData   = 64'h99;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset busy=%b err=%b exp busy=1 err=0", busy, err);
    end
    @(negedge clk);
    idle();
    reset = 1'b1;
    waitReady(cyc);
    total++;
    if (cyc != DEPTH) begin
      bad++;
      $display("FAIL mid_clear_len got=%0d exp=%0d", cyc, DEPTH);
    end
    modelReset();
    access(1'b0, 1'b1, 64'h08, '0, "ld_08_reset");
    access(1'b0, 1'b1, 64'h10, '0, "ld_10_reset");
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0)      a = 64'($urandom_range(0, DEPTH * 8 - 1));
      else if (sel == 1) a = {$urandom, $urandom};
      else               a = 64'($urandom_range(0, DEPTH - 1)) * 8;
      access(1'($urandom), 1'($urandom), a, {$urandom, $urandom}, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      access(1'b1, 1'b0, 64'(i * 8), 64'(i) * 64'h0101_0101_0101_0101, "b2b_st");
    for (int i = 0; i < 8; i++)
      access(1'b0, 1'b1, 64'(i * 8), '0, "b2b_ld");
  endtask

`ifdef DMEM_PERF_CNT_EN
  task automatic test_perf_cnt();
    total++;
    if (rd_count !== 32'(mRd) || wr_count !== 32'(mWr)) begin
      bad++;
      $display("FAIL perf_cnt rd=%0d wr=%0d exp rd=%0d wr=%0d",
               rd_count, wr_count, mRd, mWr);
    end
  endtask
`endif

  initial begin
    modelReset();
    test_reset();
    test_store_load();
    test_illegal();
    test_back_to_back();
    test_random();
`ifdef DMEM_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_clear_ignore();
    test_reset_midstream();
    test_random();
`ifdef DMEM_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
